// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: turns key press/release edges into per-voice
// phase increment, gate and retrigger controls. Free voices are taken lowest
// index first; when all are gated the least-recently-assigned voice is stolen.
module voice_allocator #(
  parameter int unsigned NUM_VOICES = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [15:0]              keys_in,
  output logic [NUM_VOICES*24-1:0] voice_phase_inc_out,
  output logic [NUM_VOICES-1:0]    voice_gate_out,
  output logic [NUM_VOICES-1:0]    voice_trig_out,
  output logic [NUM_VOICES*4-1:0]  voice_key_out
);

  localparam int unsigned NUM_KEYS   = 16;
  localparam int unsigned PHASE_BITS = 24;
  localparam int unsigned RANK_BITS  = 3;

  typedef enum logic {StIdle, StServe} state_e;

  // Key index to oscillator phase increment, G5 down to E4.
  function automatic logic [PHASE_BITS-1:0] key_inc(input logic [3:0] key);
    logic [PHASE_BITS-1:0] inc;
    case (key)
      4'd0:    inc = 24'h010B9A;
      4'd1:    inc = 24'h00FC63;
      4'd2:    inc = 24'h00EE69;
      4'd3:    inc = 24'h00E107;
      4'd4:    inc = 24'h00D465;
      4'd5:    inc = 24'h00C87A;
      4'd6:    inc = 24'h00BD3A;
      4'd7:    inc = 24'h00B29A;
      4'd8:    inc = 24'h00A894;
      4'd9:    inc = 24'h009F1E;
      4'd10:   inc = 24'h009630;
      4'd11:   inc = 24'h008DC1;
      4'd12:   inc = 24'h0085CD;
      4'd13:   inc = 24'h007E4A;
      4'd14:   inc = 24'h007734;
      default: inc = 24'h007084;
    endcase
    return inc;
  endfunction

  state_e                  state_q;
  logic [NUM_KEYS-1:0]     keys_q;
  logic [NUM_KEYS-1:0]     press_pend_q, press_pend_d;
  logic [NUM_KEYS-1:0]     rel_pend_q, rel_pend_d;
  logic [NUM_VOICES-1:0]   gate_q;
  logic [NUM_VOICES-1:0]   trig_q;
  logic [3:0]              key_q  [NUM_VOICES];
  logic [PHASE_BITS-1:0]   inc_q  [NUM_VOICES];
  logic [RANK_BITS-1:0]    rank_q [NUM_VOICES];

  logic [NUM_KEYS-1:0]     rise, fall;
  logic [NUM_KEYS-1:0]     rel_oh, press_oh, ev_oh;
  logic [NUM_KEYS-1:0]     proc_rel, proc_press;
  logic [NUM_KEYS-1:0]     press_kept, rel_kept, drop;
  logic                    ev_valid, ev_rel;
  logic [3:0]              ev_key;
  logic [NUM_VOICES-1:0]   free, free_oh, steal_oh, sel_oh, rel_match;
  logic [RANK_BITS-1:0]    sel_rank;

  // Edge detection, event arbitration and voice selection.
  always_comb begin
    rise = keys_in & ~keys_q;
    fall = ~keys_in & keys_q;

    // Isolate lowest set bit of each pending mask.
    rel_oh   = rel_pend_q & (~rel_pend_q + 16'd1);
    press_oh = press_pend_q & (~press_pend_q + 16'd1);

    ev_valid = (state_q == StServe) && ((|rel_pend_q) || (|press_pend_q));
    ev_rel   = |rel_pend_q;
    ev_oh    = ev_rel ? rel_oh : press_oh;

    ev_key = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (ev_oh[i]) ev_key = 4'(i);
    end

    proc_rel   = (ev_valid && ev_rel)  ? rel_oh   : '0;
    proc_press = (ev_valid && !ev_rel) ? press_oh : '0;

    // A release that arrives before its press was served cancels the note.
    press_kept   = press_pend_q & ~proc_press;
    rel_kept     = rel_pend_q & ~proc_rel;
    drop         = fall & press_kept;
    press_pend_d = (press_kept & ~drop) | rise;
    rel_pend_d   = rel_kept | (fall & ~drop);

    free    = ~gate_q;
    free_oh = free & (~free + 1'b1);

    steal_oh  = '0;
    rel_match = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (rank_q[v] == RANK_BITS'(NUM_VOICES - 1)) steal_oh[v] = 1'b1;
      rel_match[v] = gate_q[v] && (key_q[v] == ev_key);
    end

    sel_oh = (|free) ? free_oh : steal_oh;

    sel_rank = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (sel_oh[v]) sel_rank = rank_q[v];
    end
  end

  // Control FSM with all voice state and outputs registered.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= StIdle;
      keys_q       <= '0;
      press_pend_q <= '0;
      rel_pend_q   <= '0;
      gate_q       <= '0;
      trig_q       <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        key_q[v]  <= '0;
        inc_q[v]  <= '0;
        rank_q[v] <= RANK_BITS'(v);
      end
    end else begin
      keys_q       <= keys_in;
      press_pend_q <= press_pend_d;
      rel_pend_q   <= rel_pend_d;
      trig_q       <= '0;
      state_q      <= ((|press_pend_d) || (|rel_pend_d)) ? StServe : StIdle;

      if (ev_valid) begin
        if (ev_rel) begin
          // Key and increment are kept so the envelope release can play out.
          gate_q <= gate_q & ~rel_match;
        end else begin
          gate_q <= gate_q | sel_oh;
          trig_q <= sel_oh;
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (sel_oh[v]) begin
              key_q[v]  <= ev_key;
              inc_q[v]  <= key_inc(ev_key);
              rank_q[v] <= '0;
            end else if (rank_q[v] < sel_rank) begin
              rank_q[v] <= rank_q[v] + 1'b1;
            end
          end
        end
      end
    end
  end

  // Flatten per-voice registers onto the output buses.
  always_comb begin
    voice_phase_inc_out = '0;
    voice_key_out       = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_phase_inc_out[v*PHASE_BITS +: PHASE_BITS] = inc_q[v];
      voice_key_out[v*4 +: 4]                         = key_q[v];
    end
  end

  assign voice_gate_out = gate_q;
  assign voice_trig_out = trig_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: expected voice assignments are queued when keys
// are driven and checked against each trig pulse; direct checks cover reset,
// releases, steals and dropped notes.
module tb_voice_allocator;

  localparam int unsigned NV = 4;

  logic            clk;
  logic            rst;
  logic [15:0]     keys;
  logic [NV*24-1:0] phase_inc;
  logic [NV-1:0]   gate;
  logic [NV-1:0]   trig;
  logic [NV*4-1:0] vkeys;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          voice;
    logic [3:0]  key;
    logic [23:0] inc;
  } exp_t;

  exp_t sb_q[$];
  logic [NV-1:0] prev_trig;

  voice_allocator #(.NUM_VOICES(NV)) dut (
    .clk_in              (clk),
    .rst_in              (rst),
    .keys_in             (keys),
    .voice_phase_inc_out (phase_inc),
    .voice_gate_out      (gate),
    .voice_trig_out      (trig),
    .voice_key_out       (vkeys)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] key_of(input int v);
    return vkeys[v*4 +: 4];
  endfunction

  function automatic logic [23:0] inc_of(input int v);
    return phase_inc[v*24 +: 24];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_assign(input int v, input logic [3:0] k, input logic [23:0] inc);
    exp_t e;
    e.voice = v;
    e.key   = k;
    e.inc   = inc;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    keys = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Scoreboard: every trig pulse must match the oldest queued assignment.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check_eq("trig_single", 32'(trig & prev_trig), 32'h0);
      if (trig != '0) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_trig", 32'(trig), 32'h0);
        end else begin
          e = sb_q.pop_front();
          check_eq("sb_trig", 32'(trig), 32'(1 << e.voice));
          check_eq("sb_key", 32'(key_of(e.voice)), 32'(e.key));
          check_eq("sb_inc", 32'(inc_of(e.voice)), 32'(e.inc));
          check_eq("sb_gate", 32'(gate[e.voice]), 32'h1);
        end
      end
    end
    prev_trig = trig;
  end

  initial begin
    prev_trig = '0;
    rst  = 1'b1;
    keys = 16'h0000;

    // Reset hold: all outputs zero throughout.
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("rst_gate", 32'(gate), 32'h0);
      check_eq("rst_trig", 32'(trig), 32'h0);
      check_eq("rst_inc_nz", 32'(phase_inc != '0), 32'h0);
      check_eq("rst_key_nz", 32'(vkeys != '0), 32'h0);
    end
    rst = 1'b0;
    tick();

    // Lone press of key 10: one edge to register, one to assign.
    expect_assign(0, 4'd10, 24'h009630);
    keys = 16'h0400;
    tick();
    check_eq("lat_e0_gate", 32'(gate), 32'h0);
    check_eq("lat_e0_trig", 32'(trig), 32'h0);
    tick();
    check_eq("k10_gate", 32'(gate), 32'h1);
    check_eq("k10_trig", 32'(trig), 32'h1);
    check_eq("k10_key", 32'(key_of(0)), 32'd10);
    check_eq("k10_inc", 32'(inc_of(0)), 32'h009630);
    check_eq("k10_others_inc", 32'(phase_inc[NV*24-1:24] != '0), 32'h0);
    tick();
    check_eq("k10_trig_off", 32'(trig), 32'h0);
    keys = 16'h0000;
    tick();
    tick();
    check_eq("k10_rel_gate", 32'(gate), 32'h0);
    check_eq("k10_rel_inc", 32'(inc_of(0)), 32'h009630);
    check_eq("k10_rel_key", 32'(key_of(0)), 32'd10);

    // Two presses in one cycle: served on consecutive edges, lowest key first.
    do_reset();
    expect_assign(0, 4'd0, 24'h010B9A);
    expect_assign(1, 4'd3, 24'h00E107);
    keys = 16'h0009;
    tick();
    tick();
    check_eq("dual_e1_key0", 32'(key_of(0)), 32'd0);
    check_eq("dual_e1_inc0", 32'(inc_of(0)), 32'h010B9A);
    check_eq("dual_e1_gate", 32'(gate), 32'h1);
    tick();
    check_eq("dual_e2_key1", 32'(key_of(1)), 32'd3);
    check_eq("dual_e2_inc1", 32'(inc_of(1)), 32'h00E107);
    check_eq("dual_e2_trig", 32'(trig), 32'h2);
    tick();

    // Fill all voices one at a time, then steal the oldest.
    do_reset();
    expect_assign(0, 4'd0, 24'h010B9A);
    keys = 16'h0001; tick(); tick(); tick();
    expect_assign(1, 4'd1, 24'h00FC63);
    keys = 16'h0003; tick(); tick(); tick();
    expect_assign(2, 4'd2, 24'h00EE69);
    keys = 16'h0007; tick(); tick(); tick();
    expect_assign(3, 4'd3, 24'h00E107);
    keys = 16'h000F; tick(); tick(); tick();
    check_eq("full_gate", 32'(gate), 32'hF);
    expect_assign(0, 4'd15, 24'h007084);
    keys = 16'h800F;
    tick();
    tick();
    check_eq("steal_trig", 32'(trig), 32'h1);
    check_eq("steal_key", 32'(key_of(0)), 32'd15);
    check_eq("steal_inc", 32'(inc_of(0)), 32'h007084);
    check_eq("steal_gate", 32'(gate), 32'hF);
    tick();
    // Release of the stolen key 0 must change nothing.
    keys = 16'h800E;
    tick(); tick(); tick();
    check_eq("stolen_rel_gate", 32'(gate), 32'hF);
    check_eq("stolen_rel_key", 32'(key_of(0)), 32'd15);
    check_eq("stolen_rel_trig", 32'(trig), 32'h0);

    // Release key 2, then press key 5 into the freed voice.
    keys = 16'h800A;
    tick();
    tick();
    check_eq("rel2_gate", 32'(gate), 32'hB);
    check_eq("rel2_inc", 32'(inc_of(2)), 32'h00EE69);
    check_eq("rel2_key", 32'(key_of(2)), 32'd2);
    expect_assign(2, 4'd5, 24'h00C87A);
    keys = 16'h802A;
    tick();
    tick();
    check_eq("p5_gate", 32'(gate), 32'hF);
    check_eq("p5_trig", 32'(trig), 32'h4);
    check_eq("p5_key", 32'(key_of(2)), 32'd5);
    check_eq("p5_inc", 32'(inc_of(2)), 32'h00C87A);
    tick();

    // Key 7 pulsed while four presses are pending is dropped.
    do_reset();
    expect_assign(0, 4'd0, 24'h010B9A);
    expect_assign(1, 4'd1, 24'h00FC63);
    expect_assign(2, 4'd2, 24'h00EE69);
    expect_assign(3, 4'd3, 24'h00E107);
    keys = 16'h000F;
    tick();
    keys = 16'h008F;
    tick();
    check_eq("pulse_e1_trig", 32'(trig), 32'h1);
    keys = 16'h000F;
    tick();
    tick();
    tick();
    check_eq("pulse_e4_trig", 32'(trig), 32'h8);
    for (int i = 0; i < 4; i++) tick();
    check_eq("pulse_keys", 32'(vkeys), 32'h3210);
    check_eq("pulse_gate", 32'(gate), 32'hF);
    check_eq("pulse_sb_empty", 32'(sb_q.size()), 32'h0);

    // Reset mid-service discards pending events.
    do_reset();
    keys = 16'h00F0;
    tick();
    rst = 1'b1;
    tick();
    check_eq("midrst_gate", 32'(gate), 32'h0);
    check_eq("midrst_trig", 32'(trig), 32'h0);
    check_eq("midrst_inc_nz", 32'(phase_inc != '0), 32'h0);
    check_eq("midrst_key_nz", 32'(vkeys != '0), 32'h0);
    keys = 16'h0000;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("postrst_gate", 32'(gate), 32'h0);
    end
    check_eq("final_sb_empty", 32'(sb_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
